// File: rtl/parking_gate_ctrl_pkg.sv
// Shared parking-lot definitions: default sizing, counter direction codes,
// controller state encoding and arbitration pointer.
package parking_gate_ctrl_pkg;

    localparam int unsigned DEF_WIDTH     = 3;
    localparam int unsigned DEF_CAP       = 7;
    localparam int unsigned DEF_GATE_TIME = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2
    } gate_state_t;

    // Which side wins when entry and exit are both eligible in IDLE.
    typedef enum logic {
        PRI_EXIT  = 1'b0,
        PRI_ENTRY = 1'b1
    } pri_t;

    // Bits needed to hold GATE_TIME-1 (at least one bit).
    function automatic int unsigned timer_width(input int unsigned gate_time);
        return (gate_time <= 2) ? 1 : $clog2(gate_time);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Request/count/gate bundle between car-detect, counter and gate controller.
interface parking_gate_ctrl_if
    import parking_gate_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             entry_req;
    logic             exit_req;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             updown;
    logic             gate_in;
    logic             gate_out;
    logic             full;
    logic             empty;
    logic             denied;
    logic             busy;

    // Environment side: car detect and occupancy counter.
    modport master (
        output entry_req, exit_req, count,
        input  cnt_en, updown, gate_in, gate_out, full, empty, denied, busy
    );

    // Gate controller side.
    modport slave (
        input  entry_req, exit_req, count,
        output cnt_en, updown, gate_in, gate_out, full, empty, denied, busy
    );
endinterface

// File: rtl/parking_gate_timer.sv
// Loadable down-counter timing how long a gate stays open; shared by both
// gates since at most one is open at a time.
module parking_gate_timer #(
    parameter int unsigned TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_done,
    output logic          o_last
);
    logic [TW-1:0] r_cnt;

    // Load on gate open, then count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);
    assign o_last = (r_cnt == TW'(1));
endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: arbitrates entry/exit requests, opens one gate
// for GATE_TIME cycles per admitted car and pulses the occupancy counter.
module parking_gate_ctrl
    import parking_gate_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CAP       = DEF_CAP,
    parameter int unsigned GATE_TIME = DEF_GATE_TIME
) (
    input  logic                clk,
    input  logic                reset,
    parking_gate_ctrl_if.slave  bus
);
    localparam int unsigned      TW            = timer_width(GATE_TIME);
    localparam logic [WIDTH-1:0] CAP_W         = WIDTH'(CAP);
    localparam logic [TW-1:0]    LOAD_W        = TW'(GATE_TIME - 1);
    localparam logic             FIRST_IS_LAST = (GATE_TIME == 1);

    gate_state_t r_state, w_state_next;
    pri_t        r_ptr, w_ptr_next;

    logic w_full, w_empty, w_entry_ok, w_exit_ok;
    logic w_load, w_tmr_done, w_tmr_last;
    logic w_cnt_en_next, w_denied_next, w_updown_next;
    logic r_cnt_en, r_updown, r_gate_in, r_gate_out, r_denied, r_busy;

    assign w_full  = (bus.count >= CAP_W);
    assign w_empty = (bus.count == '0);

    parking_gate_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (LOAD_W),
        .i_en       (r_state != ST_IDLE),
        .o_done     (w_tmr_done),
        .o_last     (w_tmr_last)
    );

    // State and arbitration pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= PRI_EXIT;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next-state, arbitration and next values of the registered outputs.
    // cnt_en is decided one cycle early so the registered pulse lands in the
    // cycle where the timer reads zero.
    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_load        = 1'b0;
        w_cnt_en_next = 1'b0;
        w_denied_next = 1'b0;
        w_updown_next = r_updown;
        w_entry_ok    = bus.entry_req && !w_full;
        w_exit_ok     = bus.exit_req && !w_empty;
        unique case (r_state)
            ST_IDLE: begin
                w_denied_next = bus.entry_req && w_full && !w_exit_ok;
                if (w_entry_ok && w_exit_ok) begin
                    w_state_next = (r_ptr == PRI_EXIT) ? ST_OPEN_OUT : ST_OPEN_IN;
                    w_ptr_next   = (r_ptr == PRI_EXIT) ? PRI_ENTRY : PRI_EXIT;
                end else if (w_entry_ok) begin
                    w_state_next = ST_OPEN_IN;
                end else if (w_exit_ok) begin
                    w_state_next = ST_OPEN_OUT;
                end
                if (w_state_next != ST_IDLE) begin
                    w_load        = 1'b1;
                    w_cnt_en_next = FIRST_IS_LAST;
                    w_updown_next = (w_state_next == ST_OPEN_IN) ? DIR_UP : DIR_DOWN;
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                if (w_tmr_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_en_next = w_tmr_last;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_en   <= 1'b0;
            r_updown   <= 1'b0;
            r_gate_in  <= 1'b0;
            r_gate_out <= 1'b0;
            r_denied   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt_en   <= w_cnt_en_next;
            r_updown   <= w_updown_next;
            r_gate_in  <= (w_state_next == ST_OPEN_IN);
            r_gate_out <= (w_state_next == ST_OPEN_OUT);
            r_denied   <= w_denied_next;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign bus.cnt_en   = r_cnt_en;
    assign bus.updown   = r_updown;
    assign bus.gate_in  = r_gate_in;
    assign bus.gate_out = r_gate_out;
    assign bus.denied   = r_denied;
    assign bus.busy     = r_busy;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
endmodule
